// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: default
// bundle widths per stage boundary, control-bit positions and counter width.
package mips_pipe_pkg;

    // Default data bundle widths for each stage boundary
    localparam int NDATA_IF_ID  = 64;
    localparam int NDATA_ID_EX  = 128;
    localparam int NDATA_EX_MEM = 112;
    localparam int NDATA_MEM_WB = 72;
    localparam int NDATA_DEF    = 128;

    // Default control bundle width (M and WB fields)
    localparam int NCTRL_DEF = 12;

    // Performance counter width
    localparam int CNTW_DEF = 16;

    // Control-bit positions, M field
    localparam int CTRL_M_MEM_READ     = 0;
    localparam int CTRL_M_MEM_WRITE    = 1;
    localparam int CTRL_M_SIZE_LO      = 2;
    localparam int CTRL_M_SIZE_HI      = 3;
    localparam int CTRL_M_UNSIGNED     = 4;
    localparam int CTRL_M_BRANCH       = 5;
    // Control-bit positions, WB field
    localparam int CTRL_WB_REG_WRITE   = 6;
    localparam int CTRL_WB_MEM_TO_REG  = 7;
    localparam int CTRL_WB_LINK        = 8;
    localparam int CTRL_WB_HALT        = 9;
    localparam int CTRL_WB_SEL_LO      = 10;
    localparam int CTRL_WB_SEL_HI      = 11;

    // Per-cycle action taken by a stage register once reset is excluded
    typedef enum logic [1:0] {
        OP_FREEZE = 2'd0,
        OP_FLUSH  = 2'd1,
        OP_STALL  = 2'd2,
        OP_LOAD   = 2'd3
    } pipe_op_e;

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with enable, clear and synchronous reset.
// Clear wins over a coincident increment; nothing moves while en = 0.
module contador_saturado #(
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic            i_inc,
    input  logic            i_clr,
    output logic [CNTW-1:0] o_count
);

    logic [CNTW-1:0] count_r;
    logic [CNTW-1:0] count_next_s;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_next_s = count_r;
        if (!i_en) begin
            count_next_s = count_r;
        end else if (i_clr) begin
            count_next_s = {CNTW{1'b0}};
        end else if (i_inc && (count_r != {CNTW{1'b1}})) begin
            count_next_s = count_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_r <= {CNTW{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign o_count = count_r;

endmodule

// File: rtl/etapa_pipe_reg.sv
// Generic inter-stage pipeline register: data bundle, control bundle and
// valid bit, with stall, flush (bubble), debug freeze and perf counters.
module etapa_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int NDATA               = NDATA_DEF,
    parameter int NCTRL               = NCTRL_DEF,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
    parameter int CNTW                = CNTW_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [NDATA-1:0] i_data,
    input  logic [NCTRL-1:0] i_ctrl,
    input  logic             i_clr_counts,
    output logic             o_valid,
    output logic [NDATA-1:0] o_data,
    output logic [NCTRL-1:0] o_ctrl,
    output logic [CNTW-1:0]  o_stall_count,
    output logic [CNTW-1:0]  o_bubble_count
);

    pipe_op_e         op_s;
    logic             valid_r;
    logic [NDATA-1:0] data_r;
    logic [NCTRL-1:0] ctrl_r;
    logic             valid_next_s;
    logic [NDATA-1:0] data_next_s;
    logic [NCTRL-1:0] ctrl_next_s;
    logic             stall_inc_s;

    // Decode the action for this cycle: freeze > flush > stall > load
    always_comb begin
        op_s = OP_LOAD;
        if (!i_enable) begin
            op_s = OP_FREEZE;
        end else if (i_flush) begin
            op_s = OP_FLUSH;
        end else if (i_stall) begin
            op_s = OP_STALL;
        end else begin
            op_s = OP_LOAD;
        end
    end

    // Next register contents; a bubble always carries zero control bits
    always_comb begin
        valid_next_s = valid_r;
        data_next_s  = data_r;
        ctrl_next_s  = ctrl_r;
        case (op_s)
            OP_FREEZE: begin
                valid_next_s = valid_r;
                data_next_s  = data_r;
                ctrl_next_s  = ctrl_r;
            end
            OP_FLUSH: begin
                valid_next_s = 1'b0;
                ctrl_next_s  = {NCTRL{1'b0}};
                if (CLEAR_DATA_ON_FLUSH) begin
                    data_next_s = {NDATA{1'b0}};
                end else begin
                    data_next_s = data_r;
                end
            end
            OP_STALL: begin
                valid_next_s = valid_r;
                data_next_s  = data_r;
                ctrl_next_s  = ctrl_r;
            end
            OP_LOAD: begin
                valid_next_s = i_valid;
                data_next_s  = i_data;
                if (i_valid) begin
                    ctrl_next_s = i_ctrl;
                end else begin
                    ctrl_next_s = {NCTRL{1'b0}};
                end
            end
            default: begin
                valid_next_s = valid_r;
                data_next_s  = data_r;
                ctrl_next_s  = ctrl_r;
            end
        endcase
    end

    // Stage registers; reset overrides freeze and everything else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_r <= 1'b0;
            data_r  <= {NDATA{1'b0}};
            ctrl_r  <= {NCTRL{1'b0}};
        end else begin
            valid_r <= valid_next_s;
            data_r  <= data_next_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    // A flush cycle counts as a bubble, never as a stall
    assign stall_inc_s = i_stall & ~i_flush;

    contador_saturado #(.CNTW(CNTW)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_enable),
        .i_inc   (stall_inc_s),
        .i_clr   (i_clr_counts),
        .o_count (o_stall_count)
    );

    contador_saturado #(.CNTW(CNTW)) u_bubble_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_enable),
        .i_inc   (i_flush),
        .i_clr   (i_clr_counts),
        .o_count (o_bubble_count)
    );

    assign o_valid = valid_r;
    assign o_data  = data_r;
    assign o_ctrl  = ctrl_r;

endmodule
